ps2_scancode_decoder: RTL

//   Downstream of the PS/2 receiver: consumes raw set-2 scancode bytes and assembles
//   key events (make/break, E0-extended, typematic repeat, optional ASCII). Events are

---
 rtl/ps2_scancode_decoder.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// Set-2 scancode bytes -> make/break/repeat key events, queued for an MMIO reader (ASCII table: PS2_ASCII_EN).
// Latency: an event shows on out_valid one cycle after its final byte is strobed in.
// Backpressure: none upstream; a full FIFO drops the new event and sets sticky overflow.

module ps2_sc_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             vld,
    output logic             full,
    output logic [WIDTH-1:0] head_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign vld      = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && vld;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

module ps2_scancode_decoder #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic             out_ext,
    output logic             out_release,
    output logic             out_repeat,
    output logic [7:0]       out_ascii,
    output logic             held,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       emit;
    logic       emit_ext;
    logic       emit_rel;
    logic       is_e0;
    logic       is_f0;
    logic       is_noise;
    logic [8:0] held_key;
    logic [8:0] ev_key;
    logic       key_match;
    logic       ev_repeat;
    logic       fifo_full;
    logic       fifo_pop;

`ifdef PS2_ASCII_EN
    localparam int EW = 19;

    function automatic logic [7:0] set2_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
            8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
            8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
            8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
            8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
            8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    logic [7:0] ev_ascii;
    assign ev_ascii = (emit_ext || emit_rel) ? 8'h00 : set2_ascii(in_data);
`else
    localparam int EW = 11;
`endif

    logic [EW-1:0] push_dat;
    logic [EW-1:0] head_dat;

    assign is_e0    = (in_data == 8'hE0);
    assign is_f0    = (in_data == 8'hF0);
    // BAT result, ACK, echo and error bytes carry no key information.
    assign is_noise = (in_data == 8'hAA) || (in_data == 8'hFA) || (in_data == 8'hEE) ||
                      (in_data == 8'h00) || (in_data == 8'hFF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_rel  = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (is_e0) begin
                        state_nxt = EXT;
                    end else if (is_f0) begin
                        state_nxt = BRK;
                    end else if (!is_noise) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (is_f0) begin
                        state_nxt = EXT_BRK;
                    end else if (!is_e0) begin
                        emit      = 1'b1;
                        emit_ext  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    state_nxt = IDLE;
                    if (!is_e0 && !is_f0) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_nxt = IDLE;
                    if (!is_e0 && !is_f0) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign ev_key    = {emit_ext, in_data};
    assign key_match = held && (held_key == ev_key);
    assign ev_repeat = !emit_rel && key_match;

    // Held tracking follows the key stream even when the FIFO drops the event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            held      <= 1'b0;
            held_key  <= '0;
            press_cnt <= '0;
        end else if (emit) begin
            if (!emit_rel) begin
                if (!key_match) begin
                    held     <= 1'b1;
                    held_key <= ev_key;
                    if (press_cnt != '1) begin
                        press_cnt <= press_cnt + CNT_W'(1);
                    end
                end
            end else if (key_match) begin
                held <= 1'b0;
            end
        end
    end

    assign fifo_pop = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (emit && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

`ifdef PS2_ASCII_EN
    assign push_dat = {ev_ascii, ev_repeat, emit_rel, emit_ext, in_data};
    assign {out_ascii, out_repeat, out_release, out_ext, out_code} =
        out_valid ? head_dat : '0;
`else
    assign push_dat  = {ev_repeat, emit_rel, emit_ext, in_data};
    assign out_ascii = 8'h00;
    assign {out_repeat, out_release, out_ext, out_code} = out_valid ? head_dat : '0;
`endif

    ps2_sc_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (emit),
        .push_dat (push_dat),
        .pop      (out_ready),
        .vld      (out_valid),
        .full     (fifo_full),
        .head_dat (head_dat)
    );
endmodule
